// File: rtl/sprite_anim_mapper.sv
// sprite_anim_mapper: scaled animated sprite hit test, ROM addressing and registered pixel output
// Ports: vga_clk/reset_n clock and async active-low reset; DrawX/DrawY/blank/frame_start video timing;
// pos_x/pos_y sprite position; anim_en/anim_restart animation control; rom_address/rom_q sprite ROM;
// palette_index/palette_rgb palette lookup; red/green/blue/sprite_on registered pixel (latency 2).
module sprite_anim_mapper #(
  parameter int SPR_W = 21,
  parameter int SPR_H = 45,
  parameter int FRAMES = 4,
  parameter int SCALE_LOG2 = 2,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W = 13,
  parameter int IDX_W = 5,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  palette_index,
  input  logic [11:0]       palette_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on
);
  localparam int FW = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int TW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  localparam logic [10:0] W_PIX = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] H_PIX = 11'(SPR_H << SCALE_LOG2);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [FW-1:0] frame, frame_n;
  logic [TW-1:0] tick, tick_n;
  logic [9:0] cur_x, cur_y;
  logic [10:0] dx, dy;
  logic hit, hit_d, blank_d, show;
  // Unsigned 11-bit differences; the >= tests reject the wrapped values so no left/top wrap-around.
  assign dx = {1'b0, DrawX} - {1'b0, cur_x};
  assign dy = {1'b0, DrawY} - {1'b0, cur_y};
  assign hit = DrawX >= cur_x && dx < W_PIX && DrawY >= cur_y && dy < H_PIX;
  assign rom_address = hit ? ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                           + ADDR_W'(dy >> SCALE_LOG2) * ADDR_W'(SPR_W)
                           + ADDR_W'(dx >> SCALE_LOG2) : '0;
  assign palette_index = rom_q;
  assign show = blank_d && hit_d && rom_q != IDX_W'(TRANSPARENT_IDX);
  always_comb begin
    state_n = anim_en ? RUN : IDLE;
    tick_n = tick;
    frame_n = frame;
    if (anim_restart) begin
      tick_n = '0;
      frame_n = '0;
    end else if (state == RUN && frame_start) begin
      tick_n = tick == TW'(FRAME_TICKS - 1) ? '0 : tick + 1'b1;
      if (tick == TW'(FRAME_TICKS - 1)) frame_n = frame == FW'(FRAMES - 1) ? '0 : frame + 1'b1;
    end
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tick <= '0;
      frame <= '0;
      cur_x <= '0;
      cur_y <= '0;
      hit_d <= 1'b0;
      blank_d <= 1'b0;
      sprite_on <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      frame <= frame_n;
      if (frame_start) begin
        cur_x <= pos_x;
        cur_y <= pos_y;
      end
      hit_d <= hit;
      blank_d <= blank;
      sprite_on <= show;
      {red, green, blue} <= show ? palette_rgb : '0;
    end
  end
endmodule

// File: tb/tb_sprite_anim_mapper.sv
// tb_sprite_anim_mapper: directed vector bench for sprite_anim_mapper with ROM and palette models
module tb_sprite_anim_mapper;
  logic vga_clk = 1'b0;
  logic reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic blank, frame_start, anim_en, anim_restart, sprite_on;
  logic [12:0] rom_address;
  logic [4:0] rom_q, palette_index, rom_val;
  logic [11:0] palette_rgb;
  logic [3:0] red, green, blue;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int b;
    int rv;
    int addr;
    int on;
    int rgb;
  } vec_t;
  vec_t v[11];

  sprite_anim_mapper dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .anim_restart(anim_restart), .rom_address(rom_address), .rom_q(rom_q),
    .palette_index(palette_index), .palette_rgb(palette_rgb), .red(red), .green(green),
    .blue(blue), .sprite_on(sprite_on)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_val;
  assign palette_rgb = palette_index == 5'd3 ? 12'hABC
                     : {palette_index[3:0], 4'h5, ~palette_index[3:0]};

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
    end
  endtask

  initial begin
    v[0]  = '{107, 58, 1, 3, 43, 1, 'hABC};
    v[1]  = '{183, 58, 1, 3, 62, 1, 'hABC};
    v[2]  = '{184, 58, 1, 3, 0, 0, 0};
    v[3]  = '{99, 58, 1, 3, 0, 0, 0};
    v[4]  = '{107, 229, 1, 3, 925, 1, 'hABC};
    v[5]  = '{107, 230, 1, 3, 0, 0, 0};
    v[6]  = '{100, 50, 1, 3, 0, 1, 'hABC};
    v[7]  = '{107, 49, 1, 3, 0, 0, 0};
    v[8]  = '{107, 58, 1, 0, 43, 0, 0};
    v[9]  = '{107, 58, 0, 3, 43, 0, 0};
    v[10] = '{150, 100, 1, 7, 264, 1, 'h758};
    reset_n = 1'b0;
    DrawX = 10'd5;
    DrawY = 10'd5;
    blank = 1'b1;
    frame_start = 1'b0;
    pos_x = '0;
    pos_y = '0;
    anim_en = 1'b0;
    anim_restart = 1'b0;
    rom_val = 5'd3;
    repeat (3) @(negedge vga_clk);
    chk("reset_on", int'(sprite_on), 0);
    chk("reset_rgb", int'({red, green, blue}), 0);
    chk("reset_addr", int'(rom_address), 22);
    reset_n = 1'b1;
    @(negedge vga_clk);
    chk("rel1_on", int'(sprite_on), 0);
    chk("rel1_rgb", int'({red, green, blue}), 0);
    @(negedge vga_clk);
    chk("rel2_on", int'(sprite_on), 1);
    chk("rel2_rgb", int'({red, green, blue}), 'hABC);
    pos_x = 10'd100;
    pos_y = 10'd50;
    pulses(1);
    for (int i = 0; i < 11; i++) begin
      DrawX = 10'(v[i].x);
      DrawY = 10'(v[i].y);
      blank = v[i].b[0];
      rom_val = 5'(v[i].rv);
      #1 chk($sformatf("vec%0d_addr", i), int'(rom_address), v[i].addr);
      @(negedge vga_clk);
      @(negedge vga_clk);
      chk($sformatf("vec%0d_on", i), int'(sprite_on), v[i].on);
      chk($sformatf("vec%0d_rgb", i), int'({red, green, blue}), v[i].rgb);
    end
    blank = 1'b1;
    rom_val = 5'd3;
    DrawX = '0;
    DrawY = '0;
    repeat (3) @(negedge vga_clk);
    DrawX = 10'd107;
    DrawY = 10'd58;
    @(negedge vga_clk);
    DrawX = '0;
    chk("lat1_on", int'(sprite_on), 0);
    @(negedge vga_clk);
    chk("lat2_on", int'(sprite_on), 1);
    @(negedge vga_clk);
    chk("lat3_on", int'(sprite_on), 0);
    pos_x = 10'd620;
    DrawX = 10'd107;
    #1 chk("latch_hold", int'(rom_address), 43);
    DrawX = 10'd639;
    #1 chk("latch_hold_miss", int'(rom_address), 0);
    @(negedge vga_clk);
    pulses(1);
    DrawX = 10'd107;
    #1 chk("latch_moved", int'(rom_address), 0);
    DrawX = 10'd639;
    #1 chk("clip_edge", int'(rom_address), 46);
    DrawX = 10'd10;
    #1 chk("no_wrap", int'(rom_address), 0);
    pos_x = 10'd100;
    pulses(1);
    DrawX = 10'd107;
    anim_en = 1'b1;
    @(negedge vga_clk);
    pulses(7);
    chk("anim_7", int'(rom_address), 43);
    pulses(1);
    chk("anim_8", int'(rom_address), 988);
    pulses(8);
    chk("anim_16", int'(rom_address), 1933);
    pulses(16);
    chk("anim_wrap", int'(rom_address), 43);
    pulses(7);
    chk("anim_pre_rst", int'(rom_address), 43);
    anim_restart = 1'b1;
    pos_x = 10'd101;
    pulses(1);
    anim_restart = 1'b0;
    DrawX = 10'd104;
    #1 chk("restart_pos", int'(rom_address), 42);
    pulses(7);
    chk("restart_tick", int'(rom_address), 42);
    pulses(1);
    chk("restart_adv", int'(rom_address), 987);
    anim_en = 1'b0;
    @(negedge vga_clk);
    pulses(10);
    chk("idle_hold", int'(rom_address), 987);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
